// File: rtl/light_hash_core.sv
// -----------------------------------------------------------------------------
// light_hash_core
//
// Streaming light hash. Message bytes arrive over a valid/ready handshake. Each
// byte is mixed into a DIGEST_BYTES-wide state H with ROUNDS AES-Sbox rounds,
// one round per clock. After the byte flagged as last, the core folds the
// message length into a single byte, runs another ROUNDS rounds, and then holds
// the digest until the consumer takes it.
//
// Round function (all bytes updated in parallel from the old state):
//   H'[i] = sbox(H[(i+2) % N] ^ b ^ r[7:0]) ^ H[i]
//
// Parameters
//   DIGEST_BYTES  state/digest size in bytes (>= 3)
//   ROUNDS        rounds per absorbed byte (>= 1)
//   IV_SEED       H[i] resets to IV_SEED ^ i
//   LEN_W         message byte counter width (>= 8)
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   m_valid          in   message byte valid
//   m_data[7:0]      in   message byte
//   m_last           in   m_data is the final byte of the message
//   m_ready          out  byte accepted when m_valid && m_ready (IDLE only)
//   digest_valid     out  digest available (OUT state)
//   digest_ready     in   digest taken when digest_valid && digest_ready
//   digest[8N-1:0]   out  H[0] in bits [7:0] .. H[N-1] in the MSB byte
//   busy             out  core is not IDLE
//   err_invalid_char out  sticky per-message flag for non-letter bytes
//
// Optional feature (macro LH_CHAR_CHECK_EN)
//   When defined, an accepted byte outside 'A'-'Z' / 'a'-'z' sets
//   err_invalid_char (sticky until digest handshake or reset) and is absorbed
//   as 8'h00; it still counts toward the length. When undefined, the flag is
//   tied low and no range comparison exists.
// -----------------------------------------------------------------------------
module light_hash_core #(
    parameter int         DIGEST_BYTES = 16,
    parameter int         ROUNDS       = 32,
    parameter logic [7:0] IV_SEED      = 8'hA5,
    parameter int         LEN_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        m_valid,
    input  logic [7:0]                  m_data,
    input  logic                        m_last,
    output logic                        m_ready,
    output logic                        digest_valid,
    input  logic                        digest_ready,
    output logic [8*DIGEST_BYTES-1:0]   digest,
    output logic                        busy,
    output logic                        err_invalid_char
);

    localparam int NB  = DIGEST_BYTES;
    // Round counter is at least 8 bits so r[7:0] is always a plain slice.
    localparam int RW  = ($clog2(ROUNDS) > 8) ? $clog2(ROUNDS) : 8;
    localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);
    // Length zero-padded to a whole number of bytes for the final fold.
    localparam int NSL = (LEN_W + 7) / 8;
    localparam int LPW = NSL * 8;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ABSORB, FINAL, OUT} state_t;

    function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [NB-1:0][7:0] iv_state();
        logic [NB-1:0][7:0] v;
        for (int i = 0; i < NB; i++) begin
            v[i] = IV_SEED ^ 8'(i);
        end
        return v;
    endfunction

    // k is the combined byte/round key b ^ r[7:0].
    function automatic logic [NB-1:0][7:0] hash_round(input logic [NB-1:0][7:0] h,
                                                      input logic [7:0]         k);
        logic [NB-1:0][7:0] nh;
        for (int i = 0; i < NB; i++) begin
            nh[i] = aes128_sbox(h[(i + 2) % NB] ^ k) ^ h[i];
        end
        return nh;
    endfunction

    function automatic logic [7:0] len_fold(input logic [LEN_W-1:0] len);
        logic [LPW-1:0] lp;
        logic [7:0]     f;
        lp = LPW'(len);
        f  = 8'h00;
        for (int k = 0; k < NSL; k++) begin
            f = f ^ lp[8*k +: 8];
        end
        return f;
    endfunction

    state_t             state_q, state_d;
    logic [NB-1:0][7:0] h_q, h_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [RW-1:0]      rnd_q, rnd_d;
    logic [7:0]         b_q, b_d;
    logic               last_q, last_d;
    logic               fin_ld_q, fin_ld_d;   // first FINAL cycle loads the length byte
    logic [7:0]         byte_in;
    logic               err_set;
    logic               err_q, err_d;

`ifdef LH_CHAR_CHECK_EN
    logic char_ok;
    assign char_ok = ((m_data >= 8'h41) && (m_data <= 8'h5A)) ||
                     ((m_data >= 8'h61) && (m_data <= 8'h7A));
    assign byte_in = char_ok ? m_data : 8'h00;
    assign err_set = ~char_ok;
`else
    assign byte_in = m_data;
    assign err_set = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        len_d    = len_q;
        rnd_d    = rnd_q;
        b_d      = b_q;
        last_d   = last_q;
        fin_ld_d = fin_ld_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    b_d     = byte_in;
                    len_d   = len_q + 1'b1;
                    last_d  = m_last;
                    rnd_d   = '0;
                    err_d   = err_q | err_set;
                    state_d = ABSORB;
                end
            end
            ABSORB: begin
                h_d = hash_round(h_q, b_q ^ rnd_q[7:0]);
                if (rnd_q == R_LAST) begin
                    rnd_d = '0;
                    if (last_q) begin
                        fin_ld_d = 1'b1;
                        state_d  = FINAL;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
            FINAL: begin
                if (fin_ld_q) begin
                    b_d      = len_fold(len_q);
                    fin_ld_d = 1'b0;
                end else begin
                    h_d = hash_round(h_q, b_q ^ rnd_q[7:0]);
                    if (rnd_q == R_LAST) begin
                        rnd_d   = '0;
                        state_d = OUT;
                    end else begin
                        rnd_d = rnd_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (digest_ready) begin
                    h_d     = iv_state();
                    len_d   = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            h_q      <= iv_state();
            len_q    <= '0;
            rnd_q    <= '0;
            b_q      <= 8'h00;
            last_q   <= 1'b0;
            fin_ld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            len_q    <= len_d;
            rnd_q    <= rnd_d;
            b_q      <= b_d;
            last_q   <= last_d;
            fin_ld_q <= fin_ld_d;
            err_q    <= err_d;
        end
    end

    assign m_ready          = (state_q == IDLE);
    assign digest_valid     = (state_q == OUT);
    assign busy             = (state_q != IDLE);
    assign digest           = h_q;
    assign err_invalid_char = err_q;

endmodule

// File: tb/tb_light_hash_core.sv
module tb_light_hash_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m_valid = 1'b0;
    logic [7:0]   m_data = 8'h00;
    logic         m_last = 1'b0;
    logic         m_ready;
    logic         digest_valid;
    logic         digest_ready = 1'b0;
    logic [127:0] digest;
    logic         busy;
    logic         err_invalid_char;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]   sbox_tab [256];
    logic [7:0]   msg_buf [8];
    logic [127:0] exp_q [$];
    logic [127:0] iv_ref;

    light_hash_core #(
        .DIGEST_BYTES(16),
        .ROUNDS(32),
        .IV_SEED(8'hA5),
        .LEN_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_last(m_last),
        .m_ready(m_ready),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready),
        .digest(digest),
        .busy(busy),
        .err_invalid_char(err_invalid_char)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic bit is_letter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    function automatic logic [127:0] model(input int n);
        logic [7:0]  h [16];
        logic [7:0]  nh [16];
        logic [7:0]  b;
        logic [15:0] len;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) h[i] = 8'hA5 ^ 8'(i);
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                b = msg_buf[k];
`ifdef LH_CHAR_CHECK_EN
                if (!is_letter(b)) b = 8'h00;
`endif
            end else begin
                len = 16'(n);
                b   = len[7:0] ^ len[15:8];
            end
            for (int r = 0; r < 32; r++) begin
                for (int i = 0; i < 16; i++)
                    nh[i] = sbox_tab[h[(i + 2) % 16] ^ b ^ 8'(r)] ^ h[i];
                for (int i = 0; i < 16; i++) h[i] = nh[i];
            end
        end
        for (int i = 0; i < 16; i++) out[8*i +: 8] = h[i];
        return out;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input bit hold,
                             output int acc, output bit ok);
        m_valid = 1'b1;
        m_data  = d;
        m_last  = last;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (m_ready) begin
                tick();
                acc = cyc;
                ok  = 1'b1;
            end else begin
                tick();
            end
        end
        if (!hold) m_valid = 1'b0;
    endtask

    task automatic wait_digest(output int vc, output bit ok);
        ok = 1'b0;
        vc = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (digest_valid) begin
                ok = 1'b1;
                vc = cyc;
            end
        end
    endtask

    task automatic handshake();
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        m_valid = 1'b1;
        m_data  = 8'h61;
        m_last  = 1'b1;
        tick();
        tick();
        checks++;
        if (m_ready !== 1'b1 || digest_valid !== 1'b0 || busy !== 1'b0 || err_invalid_char !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b dv=%b busy=%b err=%b exp 1 0 0 0",
                     m_ready, digest_valid, busy, err_invalid_char);
        end
        m_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept got busy=%b exp 0", busy);
        end
        checks++;
        if (digest !== iv_ref) begin
            errors++;
            $display("FAIL reset_iv got %h exp %h", digest, iv_ref);
        end
    endtask

    task automatic test_single();
        int acc, vc;
        bit ok, okd;
        logic [127:0] exp;
        msg_buf[0] = 8'h61;
        send_byte(8'h61, 1'b1, 1'b0, acc, ok);
        exp_q.push_back(model(1));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_accept got no accept exp accept");
        end
        wait_digest(vc, okd);
        exp = exp_q.pop_front();
        checks++;
        if (!okd || (vc - acc) !== 65) begin
            errors++;
            $display("FAIL single_latency got %0d exp 65 (seen=%0d)", vc - acc, okd);
        end
        checks++;
        if (digest !== exp) begin
            errors++;
            $display("FAIL single_digest got %h exp %h", digest, exp);
        end
        handshake();
        checks++;
        if (digest_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release got dv=%b busy=%b exp 0 0", digest_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2, vc;
        bit o0, o1, o2, okd;
        logic [127:0] exp;
        msg_buf[0] = 8'h61;
        msg_buf[1] = 8'h62;
        msg_buf[2] = 8'h63;
        send_byte(8'h61, 1'b0, 1'b1, a0, o0);
        send_byte(8'h62, 1'b0, 1'b1, a1, o1);
        send_byte(8'h63, 1'b1, 1'b0, a2, o2);
        exp_q.push_back(model(3));
        checks++;
        if (!(o0 && o1 && o2) || (a1 - a0) !== 33) begin
            errors++;
            $display("FAIL b2b_gap01 got %0d exp 33", a1 - a0);
        end
        checks++;
        if (!(o0 && o1 && o2) || (a2 - a1) !== 33) begin
            errors++;
            $display("FAIL b2b_gap12 got %0d exp 33", a2 - a1);
        end
        wait_digest(vc, okd);
        exp = exp_q.pop_front();
        checks++;
        if (!okd || digest !== exp) begin
            errors++;
            $display("FAIL b2b_digest got %h exp %h", digest, exp);
        end
        handshake();
    endtask

    task automatic test_out_hold();
        int acc, vc, bad;
        bit ok, okd;
        logic [127:0] exp;
        msg_buf[0] = 8'h5A;
        send_byte(8'h5A, 1'b1, 1'b0, acc, ok);
        exp_q.push_back(model(1));
        wait_digest(vc, okd);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || !okd || digest !== exp) begin
            errors++;
            $display("FAIL hold_digest got %h exp %h", digest, exp);
        end
        bad = 0;
        m_valid = 1'b1;
        m_data  = 8'h41;
        m_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (digest !== exp || m_ready !== 1'b0 || busy !== 1'b1 || digest_valid !== 1'b1) bad++;
        end
        m_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable got %0d bad cycles exp 0", bad);
        end
        handshake();
        checks++;
        if (busy !== 1'b0 || m_ready !== 1'b1 || digest !== iv_ref) begin
            errors++;
            $display("FAIL hold_release got busy=%b rdy=%b h=%h exp 0 1 %h", busy, m_ready, digest, iv_ref);
        end
    endtask

    task automatic test_reset_mid();
        int acc, vc;
        bit ok, okd;
        logic [127:0] exp;
        send_byte(8'h78, 1'b0, 1'b0, acc, ok);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || digest !== iv_ref) begin
            errors++;
            $display("FAIL midreset_state got busy=%b h=%h exp 0 %h", busy, digest, iv_ref);
        end
        msg_buf[0] = 8'h61;
        send_byte(8'h61, 1'b1, 1'b0, acc, ok);
        exp_q.push_back(model(1));
        wait_digest(vc, okd);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || !okd || digest !== exp) begin
            errors++;
            $display("FAIL midreset_digest got %h exp %h", digest, exp);
        end
        handshake();
    endtask

    task automatic test_char_check();
        int acc, vc;
        bit ok, okd;
        logic [127:0] exp;
        logic exp_err;
`ifdef LH_CHAR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        msg_buf[0] = 8'h31;
        send_byte(8'h31, 1'b1, 1'b0, acc, ok);
        exp_q.push_back(model(1));
        checks++;
        if (!ok || err_invalid_char !== exp_err) begin
            errors++;
            $display("FAIL char_err_set got %b exp %b", err_invalid_char, exp_err);
        end
        wait_digest(vc, okd);
        exp = exp_q.pop_front();
        checks++;
        if (!okd || digest !== exp || err_invalid_char !== exp_err) begin
            errors++;
            $display("FAIL char_digest got %h err=%b exp %h err=%b", digest, err_invalid_char, exp, exp_err);
        end
        handshake();
        checks++;
        if (err_invalid_char !== 1'b0) begin
            errors++;
            $display("FAIL char_err_clear got %b exp 0", err_invalid_char);
        end
    endtask

    initial begin
        build_sbox();
        for (int i = 0; i < 16; i++) iv_ref[8*i +: 8] = 8'hA5 ^ 8'(i);
        test_reset();
        test_single();
        test_back_to_back();
        test_out_hold();
        test_reset_mid();
        test_char_check();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
